npc_lsu: RTL and testbench

NPC_LSU -- requirements
Module: npc_lsu

---
 rtl/npc_pkg.sv | 18 +
 rtl/npc_lsu_align.sv | 65 ++++++
 rtl/npc_lsu.sv | 153 +++++++++++++++
 tb/tb_npc_lsu.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared LSU types: access-size encodings and the load/store FSM state.
package npc_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering: store shift/strobes, load extract/extend, alignment check.
// Purely combinational, zero latency, no flow control of its own.
module npc_lsu_align
    import npc_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  size_e            size_i,
    input  logic             uns_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [NB-1:0]    wmask_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [XLEN-1:0]  rdata_o,
    output logic             err_o
);

    logic [NB-1:0]    base_mask;
    logic [XLEN-1:0]  keep_mask;
    logic [XLEN-1:0]  rdata_sh;
    logic             sgn;
    logic [OFF_W-1:0] low_mask;

    assign rdata_sh = rdata_i >> {off_i, 3'b000};
    assign wdata_o  = wdata_i << {off_i, 3'b000};
    assign wmask_o  = base_mask << off_i;

    always_comb begin
        base_mask = '1;
        keep_mask = '1;
        sgn       = rdata_sh[XLEN-1];
        case (size_i)
            SZ_B: begin
                base_mask = NB'(1);
                keep_mask = XLEN'(8'hFF);
                sgn       = rdata_sh[7];
            end
            SZ_H: begin
                base_mask = NB'(3);
                keep_mask = XLEN'(16'hFFFF);
                sgn       = rdata_sh[15];
            end
            SZ_W: begin
                base_mask = NB'(15);
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sgn       = rdata_sh[31];
            end
            default: begin
                base_mask = '1;
                keep_mask = '1;
                sgn       = rdata_sh[XLEN-1];
            end
        endcase
    end

    // Upper bits above the access width are filled with the sign unless zero-extending.
    assign rdata_o = (rdata_sh & keep_mask) | ((sgn && !uns_i) ? ~keep_mask : '0);

    assign low_mask = OFF_W'((4'd1 << size_i) - 4'd1);
    assign err_o    = (|(off_i & low_mask)) || ((XLEN == 32) && (size_i == SZ_D));

endmodule

// File: rtl/npc_lsu.sv
// Single-outstanding load/store unit: IDLE -> MEM_REQ -> MEM_WAIT -> RESP, 3 cycles min (1 on error).
// Stalls indefinitely on mem_req_ready, mem_rvalid and resp_ready; accepts only in IDLE.
module npc_lsu
    import npc_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state_q;
    logic              we_q;
    size_e             size_q;
    logic              uns_q;
    logic [OFF_W-1:0]  off_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic              mem_req_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [NB-1:0]     mem_wmask_q;

    size_e             al_size;
    logic [OFF_W-1:0]  al_off;
    logic [NB-1:0]     al_wmask;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic              al_err;
    logic              idle;

    // One aligner serves both directions: live request fields while idle, captured fields afterwards.
    assign idle    = (state_q == IDLE);
    assign al_size = idle ? size_e'(req_size) : size_q;
    assign al_off  = idle ? req_addr[OFF_W-1:0] : off_q;

    npc_lsu_align #(.XLEN(XLEN)) u_align (
        .size_i  (al_size),
        .uns_i   (uns_q),
        .off_i   (al_off),
        .wdata_i (req_wdata),
        .rdata_i (mem_rdata),
        .wmask_o (al_wmask),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata),
        .err_o   (al_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            size_q          <= SZ_B;
            uns_q           <= 1'b0;
            off_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        size_q      <= size_e'(req_size);
                        uns_q       <= req_unsigned;
                        off_q       <= req_addr[OFF_W-1:0];
                        req_ready_q <= 1'b0;
                        if (al_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q         <= MEM_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= req_we;
                            mem_addr_q      <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            mem_wdata_q     <= req_we ? al_wdata : '0;
                            mem_wmask_q     <= req_we ? al_wmask : '0;
                        end
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : al_rdata;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench for npc_lsu (XLEN=64): driver pushes expected responses, a monitor pops and compares.
module tb_npc_lsu;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_rvalid = 1'b0;
    logic [XLEN-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    npc_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rstall  = 0;
    int   n_resp  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, req);
        end
    endtask

    // Monitor: owns resp_ready, checks every response against the head of the queue.
    initial begin : monitor
        logic        prev_v;
        logic [63:0] hold_d;
        logic        hold_e;
        int          rise;
        exp_t        e;
        prev_v     = 1'b0;
        hold_d     = '0;
        hold_e     = 1'b0;
        rise       = 0;
        resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v     = 1'b0;
                resp_ready = 1'b1;
                continue;
            end
            if (resp_valid) begin
                if (!prev_v) begin
                    rise   = cyc;
                    hold_d = resp_rdata;
                    hold_e = resp_err;
                end else begin
                    chk("resp_rdata_stable", resp_rdata, hold_d);
                    chk("resp_err_stable", 64'(resp_err), 64'(hold_e));
                end
                if (rstall > 0) begin
                    resp_ready = 1'b0;
                    rstall--;
                end else begin
                    resp_ready = 1'b1;
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_resp: rdata 0x%h err %0b with nothing outstanding",
                                 resp_rdata, resp_err);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                        chk({e.name, "_err"}, 64'(resp_err), 64'(e.err));
                        if (e.lat >= 0)
                            chk({e.name, "_latency"}, 64'(rise - e.acc + 1), 64'(e.lat));
                    end
                end
            end else begin
                resp_ready = 1'b1;
            end
            prev_v = resp_valid && !resp_ready;
        end
    end

    task automatic issue(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] mrd,
                         input logic [63:0] e_addr, input logic [7:0] e_mask,
                         input logic [63:0] e_wdata, input logic [63:0] e_rd, input logic e_err,
                         input int mstall, input int rs, input int e_lat);
        exp_t e;
        int   k;
        logic mv;
        logic ok;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: req_ready stayed 0, expected 1", nm);
            req_valid = 1'b0;
            return;
        end
        rstall = rs;
        e.rdata = e_rd;
        e.err   = e_err;
        e.lat   = e_lat;
        e.acc   = cyc + 1;
        e.name  = nm;
        exp_q.push_back(e);
        @(negedge clk);
        // Scramble request inputs after acceptance; the captured copy must be used.
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = ~sz;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = ~wd;
        if (e_err) begin
            mv = mem_req_valid;
            repeat (3) begin
                @(negedge clk);
                mv = mv | mem_req_valid;
            end
            chk({nm, "_no_memreq"}, 64'(mv), 64'(0));
        end else begin
            chk({nm, "_mem_req_valid"}, 64'(mem_req_valid), 64'(1));
            chk({nm, "_mem_we"}, 64'(mem_we), 64'(we));
            chk({nm, "_mem_addr"}, mem_addr, e_addr);
            chk({nm, "_mem_wmask"}, 64'(mem_wmask), 64'(e_mask));
            chk({nm, "_mem_wdata"}, mem_wdata, e_wdata);
            ok = 1'b1;
            repeat (mstall) begin
                @(negedge clk);
                ok = ok && mem_req_valid && (mem_addr == e_addr) && (mem_wmask == e_mask)
                        && (mem_wdata == e_wdata) && (mem_we == we);
            end
            if (mstall > 0) chk({nm, "_mem_stable"}, 64'(ok), 64'(1));
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk({nm, "_mem_req_drop"}, 64'(mem_req_valid), 64'(0));
            mem_rvalid = 1'b1;
            mem_rdata  = mrd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 64'hBADB_ADBA_DBAD_BADB;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_resp_timeout: %0d responses outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   r0;
        logic rv;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_mem_addr", mem_addr, 64'h0);
        rst = 1'b0;

        issue("ld", 1'b0, 2'd3, 1'b0, 64'h8000_1008, 64'h0, 64'h1122_3344_5566_7788,
              64'h8000_1008, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 0, 0, 3);
        issue("lb", 1'b0, 2'd0, 1'b0, 64'h8000_1003, 64'h0, 64'h0000_0000_8000_0000,
              64'h8000_1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0, 0, 3);
        issue("lbu", 1'b0, 2'd0, 1'b1, 64'h8000_1003, 64'h0, 64'h0000_0000_8000_0000,
              64'h8000_1000, 8'h00, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 0, 0, 3);
        issue("sh", 1'b1, 2'd1, 1'b0, 64'h8000_1006, 64'hFFFF_FFFF_FFFF_ABCD, 64'hDEAD_BEEF_DEAD_BEEF,
              64'h8000_1000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 1'b0, 0, 0, 3);
        issue("lw_mis", 1'b0, 2'd2, 1'b0, 64'h8000_1002, 64'h0, 64'h0,
              64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 0, 0, 1);
        r0 = n_resp;
        issue("lw_stall", 1'b0, 2'd2, 1'b0, 64'h8000_1004, 64'h0, 64'h89AB_CDEF_0000_0000,
              64'h8000_1000, 8'h00, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 5, 3, -1);
        repeat (4) @(negedge clk);
        chk("lw_stall_one_resp", 64'(n_resp - r0), 64'(1));
        issue("sw", 1'b1, 2'd2, 1'b0, 64'h8000_1004, 64'hFFFF_FFFF_1234_5678, 64'hDEAD_BEEF_DEAD_BEEF,
              64'h8000_1000, 8'hF0, 64'h1234_5678_0000_0000, 64'h0, 1'b0, 0, 0, 3);
        issue("sb", 1'b1, 2'd0, 1'b0, 64'h8000_1007, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0,
              64'h8000_1000, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 1'b0, 0, 0, 3);
        issue("lhu", 1'b0, 2'd1, 1'b1, 64'h8000_1002, 64'h0, 64'h0000_0000_F00D_0000,
              64'h8000_1000, 8'h00, 64'h0, 64'h0000_0000_0000_F00D, 1'b0, 0, 0, 3);
        issue("lh", 1'b0, 2'd1, 1'b0, 64'h8000_1002, 64'h0, 64'h0000_0000_F00D_0000,
              64'h8000_1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_F00D, 1'b0, 0, 0, 3);
        issue("ld_mis", 1'b0, 2'd3, 1'b0, 64'h8000_1004, 64'h0, 64'h0,
              64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 0, 0, 1);
        issue("sh_mis", 1'b1, 2'd1, 1'b0, 64'h8000_1001, 64'h1234, 64'h0,
              64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 0, 2, 1);
        issue("lw_pos", 1'b0, 2'd2, 1'b0, 64'h8000_1000, 64'h0, 64'hFFFF_FFFF_7FFF_FFFF,
              64'h8000_1000, 8'h00, 64'h0, 64'h0000_0000_7FFF_FFFF, 1'b0, 0, 0, 3);

        // Abort a store while it waits for its acknowledge.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd3;
        req_addr  = 64'h8000_1010;
        req_wdata = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("abort_pre_mem_we", 64'(mem_we), 64'(1));
        chk("abort_pre_mem_wmask", 64'(mem_wmask), 64'hFF);
        #2 rst = 1'b1;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'(1));
        chk("abort_resp_valid", 64'(resp_valid), 64'(0));
        chk("abort_resp_err", 64'(resp_err), 64'(0));
        chk("abort_resp_rdata", resp_rdata, 64'h0);
        chk("abort_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("abort_mem_we", 64'(mem_we), 64'(0));
        chk("abort_mem_addr", mem_addr, 64'h0);
        chk("abort_mem_wdata", mem_wdata, 64'h0);
        chk("abort_mem_wmask", 64'(mem_wmask), 64'(0));
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        rv = resp_valid;
        repeat (5) begin
            @(negedge clk);
            rv = rv | resp_valid;
        end
        chk("abort_late_rvalid_no_resp", 64'(rv), 64'(0));
        chk("abort_idle_ready", 64'(req_ready), 64'(1));

        issue("ld_after_rst", 1'b0, 2'd3, 1'b0, 64'h8000_1018, 64'h0, 64'h0123_4567_89AB_CDEF,
              64'h8000_1018, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 3);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
